// File: rtl/stage_execute_md_pkg.sv
// Shared types and encodings for the execute stage with the iterative mul/div unit.
// Holds the md op/state enums, forwarding selects, ALU and branch-condition encodings.
package exec_pkg;

  typedef enum logic [1:0] {
    MD_MUL   = 2'b00,
    MD_MULHU = 2'b01,
    MD_DIVU  = 2'b10,
    MD_REMU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } md_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

endpackage

// File: rtl/stage_execute_md_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, bundled for port wiring.
// Flow control: ex_stall=1 means EX holds its instruction (IF/ID/EX frozen) and MEM receives a bubble; ex_stall=0 means EX->MEM accepts the EX result on the next edge.
interface stage_execute_md_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              mem_clear;
  logic              ex_reg_write, ex_mem_write, ex_jump, ex_jump_cond;
  logic              ex_alu_src_op1, ex_alu_src_op2, ex_pc_target_src;
  logic [2:0]        ex_jump_cond_type, ex_alu_control;
  logic [1:0]        ex_result_src;
  logic              ex_md_en;
  logic [1:0]        ex_md_op;
  logic [XLEN-1:0]   ex_pc, ex_pc_plus_4, ex_imm_ext, ex_rd1, ex_rd2, wb_result;
  logic [REG_AW-1:0] ex_rd;
  logic [1:0]        ex_op1_forward, ex_op2_forward;

  logic              mem_reg_write, mem_mem_write;
  logic [1:0]        mem_result_src;
  logic [XLEN-1:0]   mem_alu_result, mem_write_data, mem_pc_plus_4, mem_imm_ext;
  logic [REG_AW-1:0] mem_rd;
  logic              ex_pc_src;
  logic [XLEN-1:0]   ex_pc_target;
  logic              ex_stall;

  modport master (
    output mem_clear, ex_reg_write, ex_mem_write, ex_jump, ex_jump_cond,
           ex_alu_src_op1, ex_alu_src_op2, ex_pc_target_src, ex_jump_cond_type,
           ex_alu_control, ex_result_src, ex_md_en, ex_md_op, ex_pc, ex_pc_plus_4,
           ex_imm_ext, ex_rd1, ex_rd2, wb_result, ex_rd, ex_op1_forward, ex_op2_forward,
    input  mem_reg_write, mem_mem_write, mem_result_src, mem_alu_result,
           mem_write_data, mem_pc_plus_4, mem_imm_ext, mem_rd, ex_pc_src,
           ex_pc_target, ex_stall
  );

  modport slave (
    input  mem_clear, ex_reg_write, ex_mem_write, ex_jump, ex_jump_cond,
           ex_alu_src_op1, ex_alu_src_op2, ex_pc_target_src, ex_jump_cond_type,
           ex_alu_control, ex_result_src, ex_md_en, ex_md_op, ex_pc, ex_pc_plus_4,
           ex_imm_ext, ex_rd1, ex_rd2, wb_result, ex_rd, ex_op1_forward, ex_op2_forward,
    output mem_reg_write, mem_mem_write, mem_result_src, mem_alu_result,
           mem_write_data, mem_pc_plus_4, mem_imm_ext, mem_rd, ex_pc_src,
           ex_pc_target, ex_stall
  );
endinterface

// File: rtl/stage_execute_md_alu.sv
// Single-cycle ALU and branch-condition evaluator used by the execute stage.
module alu
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      ctrl,
  output logic [XLEN-1:0] y
);
  localparam int SHW = $clog2(XLEN);

  always_comb begin
    y = '0;
    case (ctrl)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLT: y = XLEN'($signed(a) < $signed(b));
      ALU_SLL: y = a << b[SHW-1:0];
      ALU_SRL: y = a >> b[SHW-1:0];
      default: y = '0;
    endcase
  end
endmodule

module jump_cond_ctrl
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      cond_type,
  output logic            cond_true
);
  always_comb begin
    cond_true = 1'b0;
    case (cond_type)
      BR_EQ:   cond_true = (a == b);
      BR_NE:   cond_true = (a != b);
      BR_LT:   cond_true = ($signed(a) <  $signed(b));
      BR_GE:   cond_true = ($signed(a) >= $signed(b));
      BR_LTU:  cond_true = (a <  b);
      BR_GEU:  cond_true = (a >= b);
      default: cond_true = 1'b0;
    endcase
  end
endmodule

// File: rtl/stage_execute_md_muldiv.sv
// Iterative unsigned multiply/divide: one shift-add or restoring-subtract step per cycle.
// acc/q form one shared 2*XLEN shift register: product {acc,q}, or remainder acc / quotient q.
module muldiv_iter
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  md_op_t          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CNT_W = $clog2(XLEN) + 1;

  md_state_t        state;
  md_op_t           op_q;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  acc, q, div;

  logic [XLEN:0]    mul_sum, shifted;
  logic [XLEN-1:0]  div_diff;
  logic             div_ge;

  always_comb begin
    mul_sum  = {1'b0, acc} + (q[0] ? {1'b0, div} : '0);
    shifted  = {acc, q[XLEN-1]};
    div_ge   = (shifted >= {1'b0, div});
    div_diff = shifted[XLEN-1:0] - div;
  end

  // Dropping start outside IDLE means ID/EX was flushed: abandon the op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= MD_MUL;
      cnt   <= '0;
      acc   <= '0;
      q     <= '0;
      div   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc   <= '0;
          q     <= a;
          div   <= b;
          op_q  <= op;
          cnt   <= CNT_W'(XLEN);
          state <= RUN;
        end
        RUN: if (!start) begin
          state <= IDLE;
        end else begin
          if (op_q[1]) begin
            acc <= div_ge ? div_diff : shifted[XLEN-1:0];
            q   <= {q[XLEN-2:0], div_ge};
          end else begin
            acc <= mul_sum[XLEN:1];
            q   <= {mul_sum[0], q[XLEN-1:1]};
          end
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign result = op_q[0] ? acc : q;
endmodule

// File: rtl/stage_execute_md.sv
// Execute stage: forwarding, ALU, branch resolution, iterative mul/div and the EX->MEM register.
module stage_execute_md
  import exec_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input logic               clk,
  input logic               reset,
  stage_execute_md_if.slave bus
);
  logic [XLEN-1:0] fwd1, fwd2, op1, op2, alu_result, md_result, ex_result;
  logic            cond_true, md_busy, md_done;

  always_comb begin
    case (bus.ex_op1_forward)
      FWD_WB:  fwd1 = bus.wb_result;
      FWD_MEM: fwd1 = bus.mem_alu_result;
      default: fwd1 = bus.ex_rd1;
    endcase
    case (bus.ex_op2_forward)
      FWD_WB:  fwd2 = bus.wb_result;
      FWD_MEM: fwd2 = bus.mem_alu_result;
      default: fwd2 = bus.ex_rd2;
    endcase
    op1 = bus.ex_alu_src_op1 ? fwd1 : '0;
    op2 = bus.ex_alu_src_op2 ? bus.ex_imm_ext : fwd2;
  end

  alu #(.XLEN(XLEN)) u_alu (.a(op1), .b(op2), .ctrl(bus.ex_alu_control), .y(alu_result));

  jump_cond_ctrl #(.XLEN(XLEN)) u_jcc (
    .a(fwd1), .b(fwd2), .cond_type(bus.ex_jump_cond_type), .cond_true(cond_true)
  );

  muldiv_iter #(.XLEN(XLEN)) u_md (
    .clk(clk), .reset(reset), .start(bus.ex_md_en), .op(md_op_t'(bus.ex_md_op)),
    .a(fwd1), .b(fwd2), .busy(md_busy), .done(md_done), .result(md_result)
  );

  // Stall covers the capture cycle in IDLE plus every RUN cycle; DONE lets the result through.
  assign bus.ex_stall     = ~reset & (md_busy | (bus.ex_md_en & ~md_done));
  assign ex_result        = (md_done & bus.ex_md_en) ? md_result : alu_result;
  assign bus.ex_pc_target = bus.ex_pc_target_src ? alu_result : bus.ex_pc + bus.ex_imm_ext;
  assign bus.ex_pc_src    = ((bus.ex_jump_cond & cond_true) | bus.ex_jump) & ~reset & ~bus.ex_md_en;

  // A flush and a stall bubble both load an all-zero entry into MEM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || bus.mem_clear || bus.ex_stall) begin
      bus.mem_reg_write  <= 1'b0;
      bus.mem_mem_write  <= 1'b0;
      bus.mem_result_src <= '0;
      bus.mem_alu_result <= '0;
      bus.mem_write_data <= '0;
      bus.mem_pc_plus_4  <= '0;
      bus.mem_imm_ext    <= '0;
      bus.mem_rd         <= '0;
    end else begin
      bus.mem_reg_write  <= bus.ex_reg_write;
      bus.mem_mem_write  <= bus.ex_mem_write;
      bus.mem_result_src <= bus.ex_result_src;
      bus.mem_alu_result <= ex_result;
      bus.mem_write_data <= fwd2;
      bus.mem_pc_plus_4  <= bus.ex_pc_plus_4;
      bus.mem_imm_ext    <= bus.ex_imm_ext;
      bus.mem_rd         <= bus.ex_rd;
    end
  end
endmodule

// File: tb/tb_stage_execute_md.sv
// Directed bench for stage_execute_md at XLEN=32 and XLEN=16 with hand-computed expectations.
module tb_stage_execute_md;
  import exec_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   n;

  always #5 clk = ~clk;

  stage_execute_md_if #(.XLEN(32), .REG_AW(5)) if32 ();
  stage_execute_md_if #(.XLEN(16), .REG_AW(5)) if16 ();

  stage_execute_md #(.XLEN(32), .REG_AW(5)) dut32 (.clk(clk), .reset(reset), .bus(if32));
  stage_execute_md #(.XLEN(16), .REG_AW(5)) dut16 (.clk(clk), .reset(reset), .bus(if16));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear32();
    if32.mem_clear = 0; if32.ex_reg_write = 0; if32.ex_mem_write = 0; if32.ex_jump = 0;
    if32.ex_jump_cond = 0; if32.ex_alu_src_op1 = 0; if32.ex_alu_src_op2 = 0;
    if32.ex_pc_target_src = 0; if32.ex_jump_cond_type = 0; if32.ex_alu_control = 0;
    if32.ex_result_src = 0; if32.ex_md_en = 0; if32.ex_md_op = 0; if32.ex_pc = 0;
    if32.ex_pc_plus_4 = 0; if32.ex_imm_ext = 0; if32.ex_rd1 = 0; if32.ex_rd2 = 0;
    if32.wb_result = 0; if32.ex_rd = 0; if32.ex_op1_forward = 0; if32.ex_op2_forward = 0;
  endtask

  task automatic clear16();
    if16.mem_clear = 0; if16.ex_reg_write = 0; if16.ex_mem_write = 0; if16.ex_jump = 0;
    if16.ex_jump_cond = 0; if16.ex_alu_src_op1 = 0; if16.ex_alu_src_op2 = 0;
    if16.ex_pc_target_src = 0; if16.ex_jump_cond_type = 0; if16.ex_alu_control = 0;
    if16.ex_result_src = 0; if16.ex_md_en = 0; if16.ex_md_op = 0; if16.ex_pc = 0;
    if16.ex_pc_plus_4 = 0; if16.ex_imm_ext = 0; if16.ex_rd1 = 0; if16.ex_rd2 = 0;
    if16.wb_result = 0; if16.ex_rd = 0; if16.ex_op1_forward = 0; if16.ex_op2_forward = 0;
  endtask

  // Counts consecutive stalled cycles from now; bounded so a stuck stall cannot hang the run.
  task automatic count_stall(input bit w16, output int cnt);
    cnt = 0;
    #1;
    while (((w16 ? if16.ex_stall : if32.ex_stall) === 1'b1) && cnt < 200) begin
      cnt++;
      tick();
    end
  endtask

  task automatic drive_md32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if32.ex_md_en = 1; if32.ex_md_op = op; if32.ex_rd1 = a; if32.ex_rd2 = b;
    if32.ex_alu_src_op1 = 1; if32.ex_alu_src_op2 = 0; if32.ex_reg_write = 1;
    if32.ex_rd = 5'd5; if32.ex_jump = 1; if32.ex_op1_forward = FWD_RF; if32.ex_op2_forward = FWD_RF;
  endtask

  task automatic run_md32(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    int cnt;
    drive_md32(op, a, b);
    count_stall(1'b0, cnt);
    check({tag, "_stall_cycles"}, cnt, 33);
    check({tag, "_pc_src_blocked"}, if32.ex_pc_src, 0);
    check({tag, "_bubble_in_mem"}, if32.mem_reg_write, 0);
    tick();
    check({tag, "_result"}, if32.mem_alu_result, exp);
    check({tag, "_reg_write"}, if32.mem_reg_write, 1);
    check({tag, "_rd"}, if32.mem_rd, 5);
    if32.ex_jump = 0;
  endtask

  initial begin
    reset = 1;
    clear32();
    clear16();
    #12;
    check("reset_mem_alu_result", if32.mem_alu_result, 0);
    check("reset_mem_reg_write", if32.mem_reg_write, 0);
    check("reset_stall", if32.ex_stall, 0);
    check("reset16_mem_alu_result", if16.mem_alu_result, 0);
    @(negedge clk);
    reset = 0;
    tick();

    // ALU path and forwarding
    if32.ex_alu_src_op1 = 1; if32.ex_alu_src_op2 = 1; if32.ex_rd1 = 32'h10;
    if32.ex_imm_ext = 0; if32.ex_reg_write = 1; if32.ex_rd = 3; if32.ex_pc_plus_4 = 32'h104;
    tick();
    check("add_result", if32.mem_alu_result, 32'h10);
    check("add_pc_plus_4", if32.mem_pc_plus_4, 32'h104);
    if32.ex_op1_forward = FWD_MEM; if32.ex_rd1 = 32'h999; if32.ex_imm_ext = 4;
    #1;
    check("fwd_mem_no_stall", if32.ex_stall, 0);
    tick();
    check("fwd_mem_result", if32.mem_alu_result, 32'h14);
    check("fwd_mem_imm", if32.mem_imm_ext, 4);
    if32.ex_op1_forward = FWD_RF; if32.ex_op2_forward = FWD_WB; if32.wb_result = 32'h100;
    if32.ex_alu_src_op2 = 0; if32.ex_rd1 = 3; if32.ex_rd2 = 32'h77; if32.ex_alu_control = ALU_SUB;
    if32.ex_result_src = 2'b10; if32.ex_mem_write = 1;
    tick();
    check("sub_fwd_wb_result", if32.mem_alu_result, 32'hFFFFFF03);
    check("sub_write_data", if32.mem_write_data, 32'h100);
    check("sub_result_src", if32.mem_result_src, 2'b10);
    check("sub_mem_write", if32.mem_mem_write, 1);
    clear32();
    if32.ex_alu_src_op1 = 0; if32.ex_alu_src_op2 = 1; if32.ex_rd1 = 5; if32.ex_imm_ext = 32'hABC;
    tick();
    check("op1_zero_result", if32.mem_alu_result, 32'hABC);

    // Branch resolution
    clear32();
    if32.ex_rd1 = 32'h55; if32.ex_rd2 = 32'h55; if32.ex_jump_cond = 1;
    if32.ex_jump_cond_type = BR_EQ; if32.ex_pc = 32'h1000; if32.ex_imm_ext = 32'h20;
    #1;
    check("beq_taken", if32.ex_pc_src, 1);
    check("beq_target", if32.ex_pc_target, 32'h1020);
    if32.ex_jump_cond_type = BR_NE; #1;
    check("bne_equal_not_taken", if32.ex_pc_src, 0);
    if32.ex_rd1 = 1; if32.ex_rd2 = 32'hFFFFFFFF; if32.ex_jump_cond_type = BR_LTU; #1;
    check("bltu_taken", if32.ex_pc_src, 1);
    if32.ex_jump_cond_type = BR_LT; #1;
    check("blt_not_taken", if32.ex_pc_src, 0);
    clear32();
    if32.ex_jump = 1; if32.ex_pc_target_src = 1; if32.ex_alu_src_op1 = 1;
    if32.ex_alu_src_op2 = 1; if32.ex_rd1 = 32'h2000; if32.ex_imm_ext = 8; #1;
    check("jalr_taken", if32.ex_pc_src, 1);
    check("jalr_target", if32.ex_pc_target, 32'h2008);
    tick();
    clear32();

    // Multiply / divide, DIVU then REMU back to back
    run_md32("mul", MD_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
    run_md32("mulhu", MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_md32("divu", MD_DIVU, 32'd100, 32'd7, 32'd14);
    run_md32("remu", MD_REMU, 32'd100, 32'd7, 32'd2);
    run_md32("divu_by_zero", MD_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF);
    run_md32("remu_by_zero", MD_REMU, 32'd5, 32'd0, 32'd5);
    if32.ex_md_en = 0;
    tick();

    // Flush during RUN aborts the op
    drive_md32(MD_MUL, 32'd3, 32'd3);
    if32.ex_jump = 0;
    repeat (5) tick();
    if32.ex_md_en = 0; if32.ex_rd1 = 32'h40; if32.ex_rd2 = 2; if32.ex_reg_write = 1; if32.ex_rd = 7;
    #1;
    check("abort_stall_in_run", if32.ex_stall, 1);
    tick();
    check("abort_state_idle", dut32.u_md.state, IDLE);
    check("abort_bubble_reg_write", if32.mem_reg_write, 0);
    check("abort_bubble_rd", if32.mem_rd, 0);
    check("abort_no_stall", if32.ex_stall, 0);
    tick();
    check("after_abort_result", if32.mem_alu_result, 32'h42);
    check("after_abort_rd", if32.mem_rd, 7);
    clear32();

    // Asynchronous reset at RUN cycle 10, with a live entry held in the 16-bit MEM register
    if16.ex_alu_src_op1 = 1; if16.ex_alu_src_op2 = 1; if16.ex_rd1 = 16'h1234;
    if16.ex_imm_ext = 1; if16.ex_reg_write = 1; if16.ex_rd = 4;
    drive_md32(MD_MUL, 32'd9, 32'd9);
    if32.ex_jump = 0;
    tick();
    check("pre_reset16_result", if16.mem_alu_result, 16'h1235);
    clear16();
    repeat (9) tick();
    check("run10_stall", if32.ex_stall, 1);
    reset = 1;
    #1;
    check("reset_run_stall", if32.ex_stall, 0);
    check("reset_run_state", dut32.u_md.state, IDLE);
    check("reset_run_mem16_result", if16.mem_alu_result, 0);
    check("reset_run_mem16_reg_write", if16.mem_reg_write, 0);
    check("reset_run_mem16_rd", if16.mem_rd, 0);
    if32.ex_md_en = 0;
    #1;
    reset = 0;
    tick();

    // XLEN=16 instance
    clear16();
    if16.ex_md_en = 1; if16.ex_md_op = MD_MUL; if16.ex_rd1 = 16'd300; if16.ex_rd2 = 16'd300;
    if16.ex_alu_src_op1 = 1; if16.ex_reg_write = 1; if16.ex_rd = 9;
    count_stall(1'b1, n);
    check("mul16_stall_cycles", n, 17);
    tick();
    check("mul16_result", if16.mem_alu_result, 16'h5F90);
    check("mul16_rd", if16.mem_rd, 9);
    if16.ex_md_en = 0;
    tick();
    if16.ex_md_en = 1;
    count_stall(1'b1, n);
    check("mul16_clear_stall_cycles", n, 17);
    if16.mem_clear = 1;
    tick();
    check("mul16_clear_result", if16.mem_alu_result, 0);
    check("mul16_clear_reg_write", if16.mem_reg_write, 0);
    check("mul16_clear_rd", if16.mem_rd, 0);
    check("mul16_clear_state_idle", dut16.u_md.state, IDLE);
    clear16();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
